// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter in front of a multi-read/single-write storage block (fetch reads, load/store reads+writes).
// Define MEMARB_LS_PRIORITY_EN to make load/store win every tie instead of round-robin.
module mem_access_arbiter #(
  parameter int unsigned ADDR_SIZE   = 28,
  parameter int unsigned ROW_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetchReq,
  input  logic [ADDR_SIZE-1:0]   fetchAddr,
  output logic [ROW_WIDTH-1:0]   fetchRdata,
  output logic                   fetchValid,
  input  logic                   lsReq,
  input  logic                   lsWrite,
  input  logic [ADDR_SIZE-1:0]   lsAddr,
  input  logic [ROW_WIDTH-1:0]   lsWdata,
  output logic [ROW_WIDTH-1:0]   lsRdata,
  output logic                   lsValid,
  output logic [2*ADDR_SIZE-1:0] memReadAddrs,
  output logic [1:0]             memReadEns,
  output logic [ADDR_SIZE-1:0]   memWriteAddr,
  output logic [ROW_WIDTH-1:0]   memWriteData,
  output logic                   memWriteEn,
  input  logic [ROW_WIDTH-1:0]   memReadData,
  output logic                   busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   owner_q, owner_d;
  logic                   last_owner_q, last_owner_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [ROW_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [ROW_WIDTH-1:0]   fetch_rdata_q, fetch_rdata_d;
  logic [ROW_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   ls_valid_q, ls_valid_d;
  logic                   busy_q, busy_d;
  logic [1:0]             rd_en_q, rd_en_d;
  logic                   we_q, we_d;
  logic                   grant_ls_c;

  // Winner selection when both requesters are present in IDLE
`ifdef MEMARB_LS_PRIORITY_EN
  assign grant_ls_c = lsReq;
`else
  assign grant_ls_c = lsReq & (~fetchReq | ~last_owner_q);
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    fetch_rdata_d = fetch_rdata_q;
    ls_rdata_d    = ls_rdata_q;
    fetch_valid_d = 1'b0;
    ls_valid_d    = 1'b0;
    rd_en_d       = 2'b00;
    we_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetchReq || lsReq) begin
          owner_d      = grant_ls_c;
          last_owner_d = grant_ls_c;
          addr_d       = grant_ls_c ? lsAddr : fetchAddr;
          wdata_d      = grant_ls_c ? lsWdata : wdata_q;
          write_d      = grant_ls_c & lsWrite;
          cnt_d        = CNT_W'(MEM_LATENCY - 1);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!write_q) begin
            if (owner_q) ls_rdata_d    = memReadData;
            else         fetch_rdata_d = memReadData;
          end
          fetch_valid_d = ~owner_q;
          ls_valid_d    = owner_q;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Storage strobes are registered one cycle ahead from the next-state view
    if (state_d == ACCESS) begin
      if (!owner_d)      rd_en_d = 2'b01;
      else if (!write_d) rd_en_d = 2'b10;
      we_d = write_d && (cnt_d == '0);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      fetch_rdata_q <= '0;
      ls_rdata_q    <= '0;
      fetch_valid_q <= 1'b0;
      ls_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      rd_en_q       <= 2'b00;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      write_q       <= write_d;
      fetch_rdata_q <= fetch_rdata_d;
      ls_rdata_q    <= ls_rdata_d;
      fetch_valid_q <= fetch_valid_d;
      ls_valid_q    <= ls_valid_d;
      busy_q        <= busy_d;
      rd_en_q       <= rd_en_d;
      we_q          <= we_d;
    end
  end

  // Write strobe and valids are masked during reset so an aborted store never lands
  assign memWriteEn   = we_q & ~rst;
  assign fetchValid   = fetch_valid_q & ~rst;
  assign lsValid      = ls_valid_q & ~rst;
  assign memReadAddrs = {addr_q, addr_q};
  assign memReadEns   = rd_en_q;
  assign memWriteAddr = addr_q;
  assign memWriteData = wdata_q;
  assign fetchRdata   = fetch_rdata_q;
  assign lsRdata      = ls_rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: instance A uses latency 1, instance B latency 4.
module tb_mem_access_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 32;

`ifdef MEMARB_LS_PRIORITY_EN
  localparam logic [3:0] RR_EXP = 4'b1111;
`else
  localparam logic [3:0] RR_EXP = 4'b1010;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_freq, a_fvalid, a_lreq, a_lwrite, a_lvalid, a_we, a_busy;
  logic [AW-1:0] a_faddr, a_laddr, a_waddr;
  logic [DW-1:0] a_frdata, a_lwdata, a_lrdata, a_wdata_o, a_mrdata;
  logic [2*AW-1:0] a_raddrs;
  logic [1:0]    a_rens;

  logic          b_freq, b_fvalid, b_lreq, b_lwrite, b_lvalid, b_we, b_busy;
  logic [AW-1:0] b_faddr, b_laddr, b_waddr;
  logic [DW-1:0] b_frdata, b_lwdata, b_lrdata, b_wdata_o, b_mrdata;
  logic [2*AW-1:0] b_raddrs;
  logic [1:0]    b_rens;

  logic          pk_en, pk_sel;
  logic [7:0]    pk_addr;
  logic [DW-1:0] pk_data;
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];

  int n_cmp = 0;
  int n_err = 0;

  mem_access_arbiter #(.ADDR_SIZE(AW), .ROW_WIDTH(DW), .MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .fetchReq(a_freq), .fetchAddr(a_faddr), .fetchRdata(a_frdata), .fetchValid(a_fvalid),
    .lsReq(a_lreq), .lsWrite(a_lwrite), .lsAddr(a_laddr), .lsWdata(a_lwdata),
    .lsRdata(a_lrdata), .lsValid(a_lvalid),
    .memReadAddrs(a_raddrs), .memReadEns(a_rens), .memWriteAddr(a_waddr),
    .memWriteData(a_wdata_o), .memWriteEn(a_we), .memReadData(a_mrdata), .busy(a_busy)
  );

  mem_access_arbiter #(.ADDR_SIZE(AW), .ROW_WIDTH(DW), .MEM_LATENCY(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .fetchReq(b_freq), .fetchAddr(b_faddr), .fetchRdata(b_frdata), .fetchValid(b_fvalid),
    .lsReq(b_lreq), .lsWrite(b_lwrite), .lsAddr(b_laddr), .lsWdata(b_lwdata),
    .lsRdata(b_lrdata), .lsValid(b_lvalid),
    .memReadAddrs(b_raddrs), .memReadEns(b_rens), .memWriteAddr(b_waddr),
    .memWriteData(b_wdata_o), .memWriteEn(b_we), .memReadData(b_mrdata), .busy(b_busy)
  );

  // Storage models: combinational read, port 1 wins, posedge write
  always_comb a_mrdata = a_rens[1] ? mem_a[a_raddrs[AW+7:AW]] : mem_a[a_raddrs[7:0]];
  always_comb b_mrdata = b_rens[1] ? mem_b[b_raddrs[AW+7:AW]] : mem_b[b_raddrs[7:0]];

  always @(posedge clk) begin
    if (a_we) mem_a[a_waddr[7:0]] <= a_wdata_o;
    else if (pk_en && !pk_sel) mem_a[pk_addr] <= pk_data;
    if (b_we) mem_b[b_waddr[7:0]] <= b_wdata_o;
    else if (pk_en && pk_sel) mem_b[pk_addr] <= pk_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic poke(input bit sel, input logic [7:0] addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    pk_en = 1'b1; pk_sel = sel; pk_addr = addr; pk_data = data;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  // Issue one request on instance sel and observe it until its valid pulse
  task automatic xact(input bit sel, input bit is_ls, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, output int lat, output int en_cyc, output int we_cyc,
                      output int busy_cyc, output logic [1:0] ens_or, output int other_v);
    logic vm, vo, we, bz;
    logic [1:0] ens;
    lat = -1; en_cyc = 0; we_cyc = 0; busy_cyc = 0; ens_or = 2'b00; other_v = 0;
    @(posedge clk); #1;
    if (sel) begin
      if (is_ls) begin b_lreq = 1'b1; b_lwrite = wr; b_laddr = addr; b_lwdata = wd; end
      else begin b_freq = 1'b1; b_faddr = addr; end
    end else begin
      if (is_ls) begin a_lreq = 1'b1; a_lwrite = wr; a_laddr = addr; a_lwdata = wd; end
      else begin a_freq = 1'b1; a_faddr = addr; end
    end
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (sel) begin
        vm = is_ls ? b_lvalid : b_fvalid; vo = is_ls ? b_fvalid : b_lvalid;
        ens = b_rens; we = b_we; bz = b_busy;
      end else begin
        vm = is_ls ? a_lvalid : a_fvalid; vo = is_ls ? a_fvalid : a_lvalid;
        ens = a_rens; we = a_we; bz = a_busy;
      end
      if (ens != 2'b00) en_cyc++;
      ens_or = ens_or | ens;
      if (we) we_cyc++;
      if (bz) busy_cyc++;
      if (vo) other_v++;
      if (vm) lat = c;
    end
    @(posedge clk); #1;
    a_freq = 1'b0; a_lreq = 1'b0; b_freq = 1'b0; b_lreq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({a_fvalid, a_lvalid, a_busy, a_we, a_rens} !== 6'b0) begin n_err++; $display("FAIL reset_a_ctrl got=%b exp=000000", {a_fvalid, a_lvalid, a_busy, a_we, a_rens}); end
    n_cmp++; if ({a_frdata, a_lrdata} !== 64'h0) begin n_err++; $display("FAIL reset_a_rdata got=%h exp=0", {a_frdata, a_lrdata}); end
    n_cmp++; if ({b_fvalid, b_lvalid, b_busy, b_we, b_rens} !== 6'b0) begin n_err++; $display("FAIL reset_b_ctrl got=%b exp=000000", {b_fvalid, b_lvalid, b_busy, b_we, b_rens}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({a_busy, b_busy} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset got=%b exp=00", {a_busy, b_busy}); end
  endtask

  task automatic test_fetch();
    int lat, en_cyc, we_cyc, busy_cyc, other_v;
    logic [1:0] ens_or;
    poke(1'b0, 8'h10, 32'hDEADBEEF);
    xact(1'b0, 1'b0, 1'b0, AW'('h10), '0, lat, en_cyc, we_cyc, busy_cyc, ens_or, other_v);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
    n_cmp++; if (ens_or !== 2'b01 || en_cyc !== 1) begin n_err++; $display("FAIL fetch_read_en got=%b/%0d exp=01/1", ens_or, en_cyc); end
    n_cmp++; if (a_frdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_rdata got=%h exp=deadbeef", a_frdata); end
    n_cmp++; if (other_v !== 0 || we_cyc !== 0) begin n_err++; $display("FAIL fetch_no_ls got=%0d/%0d exp=0/0", other_v, we_cyc); end
    @(negedge clk);
    n_cmp++; if ({a_fvalid, a_busy} !== 2'b00) begin n_err++; $display("FAIL fetch_pulse_end got=%b exp=00", {a_fvalid, a_busy}); end
  endtask

  task automatic test_store_load();
    int lat, en_cyc, we_cyc, busy_cyc, other_v;
    logic [1:0] ens_or;
    xact(1'b0, 1'b1, 1'b1, AW'('h20), 32'h12345678, lat, en_cyc, we_cyc, busy_cyc, ens_or, other_v);
    n_cmp++; if (we_cyc !== 1 || ens_or !== 2'b00) begin n_err++; $display("FAIL store_strobes got=%0d/%b exp=1/00", we_cyc, ens_or); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL store_latency got=%0d exp=2", lat); end
    n_cmp++; if (mem_a[8'h20] !== 32'h12345678) begin n_err++; $display("FAIL store_row got=%h exp=12345678", mem_a[8'h20]); end
    n_cmp++; if (a_lrdata !== 32'h0) begin n_err++; $display("FAIL store_keeps_lsrdata got=%h exp=0", a_lrdata); end
    xact(1'b0, 1'b1, 1'b0, AW'('h20), '0, lat, en_cyc, we_cyc, busy_cyc, ens_or, other_v);
    n_cmp++; if (ens_or !== 2'b10 || we_cyc !== 0) begin n_err++; $display("FAIL load_strobes got=%b/%0d exp=10/0", ens_or, we_cyc); end
    n_cmp++; if (a_lrdata !== 32'h12345678) begin n_err++; $display("FAIL load_rdata got=%h exp=12345678", a_lrdata); end
    n_cmp++; if (a_frdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_keeps_frdata got=%h exp=deadbeef", a_frdata); end
  endtask

  task automatic test_round_robin();
    int n, hi, dbl, both, last_c, lat, en_cyc, we_cyc, busy_cyc, other_v;
    logic [3:0] ord;
    logic prev_f, prev_l;
    logic [1:0] ens_or;
    n = 0; hi = 0; dbl = 0; both = 0; last_c = -1; ord = 4'b0; prev_f = 1'b0; prev_l = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    a_freq = 1'b1; a_faddr = AW'('h10);
    a_lreq = 1'b1; a_lwrite = 1'b0; a_laddr = AW'('h20);
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (a_fvalid && a_lvalid) both++;
      if ((a_fvalid && prev_f) || (a_lvalid && prev_l)) dbl++;
      if (a_fvalid || a_lvalid) begin ord[n] = a_lvalid; n++; hi++; last_c = c; end
      prev_f = a_fvalid; prev_l = a_lvalid;
    end
    @(posedge clk); #1;
    a_freq = 1'b0; a_lreq = 1'b0;
    n_cmp++; if (ord !== RR_EXP) begin n_err++; $display("FAIL rr_order got=%b exp=%b", ord, RR_EXP); end
    n_cmp++; if (dbl !== 0 || both !== 0 || hi !== 4) begin n_err++; $display("FAIL rr_pulses got=%0d/%0d/%0d exp=0/0/4", dbl, both, hi); end
    n_cmp++; if (last_c !== 11) begin n_err++; $display("FAIL rr_throughput got=%0d exp=11", last_c); end
    n_cmp++; if (a_lrdata !== 32'h12345678) begin n_err++; $display("FAIL rr_ls_rdata got=%h exp=12345678", a_lrdata); end
    xact(1'b0, 1'b0, 1'b0, AW'('h10), '0, lat, en_cyc, we_cyc, busy_cyc, ens_or, other_v);
    n_cmp++; if (lat !== 2 || a_frdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rr_fetch_alone got=%0d/%h exp=2/deadbeef", lat, a_frdata); end
  endtask

  task automatic test_latency();
    int lat, en_cyc, we_cyc, busy_cyc, other_v;
    logic [1:0] ens_or;
    poke(1'b1, 8'h05, 32'hCAFEF00D);
    xact(1'b1, 1'b1, 1'b0, AW'('h5), '0, lat, en_cyc, we_cyc, busy_cyc, ens_or, other_v);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL lat4_latency got=%0d exp=5", lat); end
    n_cmp++; if (en_cyc !== 4 || ens_or !== 2'b10) begin n_err++; $display("FAIL lat4_read_en got=%0d/%b exp=4/10", en_cyc, ens_or); end
    n_cmp++; if (busy_cyc !== 5) begin n_err++; $display("FAIL lat4_busy got=%0d exp=5", busy_cyc); end
    n_cmp++; if (b_lrdata !== 32'hCAFEF00D || other_v !== 0) begin n_err++; $display("FAIL lat4_rdata got=%h/%0d exp=cafef00d/0", b_lrdata, other_v); end
  endtask

  task automatic test_reset_mid_store();
    int we_seen, v_seen;
    logic busy_mid;
    we_seen = 0; v_seen = 0;
    poke(1'b1, 8'h30, 32'h11111111);
    @(posedge clk); #1;
    b_lreq = 1'b1; b_lwrite = 1'b1; b_laddr = AW'('h30); b_lwdata = 32'hAAAAAAAA;
    @(negedge clk); if (b_we) we_seen++;
    @(posedge clk); #1;
    @(negedge clk); if (b_we) we_seen++;
    busy_mid = b_busy;
    @(posedge clk); #1;
    rst = 1'b1; b_lreq = 1'b0;
    @(negedge clk); if (b_we) we_seen++; if (b_lvalid || b_fvalid) v_seen++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk); if (b_we) we_seen++; if (b_lvalid || b_fvalid) v_seen++;
    end
    n_cmp++; if (busy_mid !== 1'b1) begin n_err++; $display("FAIL abort_in_flight got=%b exp=1", busy_mid); end
    n_cmp++; if (we_seen !== 0 || v_seen !== 0) begin n_err++; $display("FAIL abort_strobes got=%0d/%0d exp=0/0", we_seen, v_seen); end
    n_cmp++; if (mem_b[8'h30] !== 32'h11111111) begin n_err++; $display("FAIL abort_row got=%h exp=11111111", mem_b[8'h30]); end
    n_cmp++; if ({b_busy, b_rens, b_lrdata} !== 35'h0) begin n_err++; $display("FAIL abort_outputs got=%h exp=0", {b_busy, b_rens, b_lrdata}); end
  endtask

  initial begin
    rst = 1'b1;
    a_freq = 1'b0; a_faddr = '0; a_lreq = 1'b0; a_lwrite = 1'b0; a_laddr = '0; a_lwdata = '0;
    b_freq = 1'b0; b_faddr = '0; b_lreq = 1'b0; b_lwrite = 1'b0; b_laddr = '0; b_lwdata = '0;
    pk_en = 1'b0; pk_sel = 1'b0; pk_addr = '0; pk_data = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_round_robin();
    test_latency();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
